// File: rtl/cory_upsize.sv
// Narrow-to-wide stream width converter: packs K N-bit beats into one A-bit word,
// beat 0 in the low slot, with an optional last marker that flushes a partial word.
module cory_upsize #(
    parameter int N = 8,
    parameter int K = 16,
    parameter int A = N * K,
    parameter int C = $clog2(K + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    input  logic         i_a_l,
    output logic         o_a_r,
    output logic         o_z_v,
    output logic [A-1:0] o_z_d,
    output logic [C-1:0] o_z_n,
    output logic         o_z_l,
    input  logic         i_z_r
);

    logic [A-1:0] acc;
    logic [A-1:0] word_next;
    logic [C-1:0] cnt;
    logic         take;
    logic         complete;

    // A held word that is not being drained is the only thing that stalls input.
    assign o_a_r    = !o_z_v || i_z_r;
    assign take     = i_a_v && o_a_r;
    assign complete = (cnt == C'(K - 1)) || i_a_l;

    // Accumulator with the incoming beat dropped into slot cnt; slots above it are
    // forced to zero so a flushed partial word is zero-filled.
    always_comb begin
        word_next = acc;
        for (int i = 0; i < K; i++) begin
            if (C'(i) == cnt) begin
                word_next[i*N +: N] = i_a_d;
            end else if (C'(i) > cnt) begin
                word_next[i*N +: N] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            cnt   <= '0;
            o_z_v <= 1'b0;
            o_z_d <= '0;
            o_z_n <= '0;
            o_z_l <= 1'b0;
        end else if (take && complete) begin
            // A completing beat reloads the output even while the old word drains.
            o_z_v <= 1'b1;
            o_z_d <= word_next;
            o_z_n <= cnt + C'(1);
            o_z_l <= i_a_l;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            if (o_z_v && i_z_r) begin
                o_z_v <= 1'b0;
            end
            if (take) begin
                acc <= word_next;
                cnt <= cnt + C'(1);
            end
        end
    end

endmodule

// File: tb/tb_cory_upsize.sv
// Bench for cory_upsize: K=4 instance checked against a beat-queue reference model,
// plus a K=1 instance for single-beat words.
module tb_cory_upsize;

    localparam int N = 8;
    localparam int K = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_a_v, i_a_l, o_a_r, o_z_v, o_z_l, i_z_r;
    logic [7:0]  i_a_d;
    logic [31:0] o_z_d;
    logic [2:0]  o_z_n;

    logic        b_i_a_v, b_i_a_l, b_o_a_r, b_o_z_v, b_o_z_l, b_i_z_r;
    logic [7:0]  b_i_a_d;
    logic [7:0]  b_o_z_d;
    logic [0:0]  b_o_z_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cory_upsize #(.N(N), .K(K)) dut (
        .clk(clk), .reset(reset),
        .i_a_v(i_a_v), .i_a_d(i_a_d), .i_a_l(i_a_l), .o_a_r(o_a_r),
        .o_z_v(o_z_v), .o_z_d(o_z_d), .o_z_n(o_z_n), .o_z_l(o_z_l), .i_z_r(i_z_r)
    );

    cory_upsize #(.N(N), .K(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_a_v(b_i_a_v), .i_a_d(b_i_a_d), .i_a_l(b_i_a_l), .o_a_r(b_o_a_r),
        .o_z_v(b_o_z_v), .o_z_d(b_o_z_d), .o_z_n(b_o_z_n), .o_z_l(b_o_z_l), .i_z_r(b_i_z_r)
    );

    // Reference model: a queue of pending beats and the single word the converter
    // should currently be presenting. Updated at the negative edge, where inputs
    // and outputs are both stable for the coming rising edge.
    logic [7:0]  part[$];
    bit          model_v = 0;
    logic [31:0] model_d;
    logic [2:0]  model_n;
    logic        model_l;
    int          words_made = 0;
    int          dut_words  = 0;

    always @(negedge clk) begin
        bit acc_in, acc_out;
        if (reset) begin
            part.delete();
            model_v = 0;
        end else begin
            n_checks++;
            if (o_z_v !== model_v) $display("FAIL mon_valid: got %b expected %b at %0t", o_z_v, model_v, $time);
            else n_pass++;
            n_checks++;
            if (o_a_r !== (!model_v || i_z_r)) $display("FAIL mon_ready: got %b expected %b at %0t", o_a_r, (!model_v || i_z_r), $time);
            else n_pass++;
            if (model_v) begin
                n_checks++;
                if ({o_z_d, o_z_n, o_z_l} !== {model_d, model_n, model_l})
                    $display("FAIL mon_word: got d=%h n=%0d l=%b expected d=%h n=%0d l=%b at %0t",
                             o_z_d, o_z_n, o_z_l, model_d, model_n, model_l, $time);
                else n_pass++;
            end
            if (o_z_v === 1'b1 && i_z_r === 1'b1) dut_words++;
            acc_out = model_v && i_z_r;
            acc_in  = i_a_v && (!model_v || i_z_r);
            if (acc_out) model_v = 0;
            if (acc_in) begin
                part.push_back(i_a_d);
                if (i_a_l || part.size() == K) begin
                    model_d = 32'h0;
                    foreach (part[i]) model_d = model_d | (32'(part[i]) << (8 * i));
                    model_n = 3'(part.size());
                    model_l = i_a_l;
                    model_v = 1;
                    words_made++;
                    part.delete();
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        bit got = 0;
        i_a_v = 1'b1; i_a_d = d; i_a_l = l;
        for (int w = 0; w < 200 && !got; w++) begin
            @(negedge clk);
            if (o_a_r === 1'b1) got = 1;
            @(posedge clk); #1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL send_timeout: beat %h not accepted within 200 cycles", d);
        end
        i_a_v = 1'b0; i_a_d = 'x; i_a_l = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_a_v = 1'b0; i_a_l = 1'b0; i_a_d = 'x; i_z_r = 1'b0;
        b_i_a_v = 1'b0; b_i_a_l = 1'b0; b_i_a_d = 'x; b_i_z_r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_z_v !== 1'b0) $display("FAIL reset_v: got %b expected 0", o_z_v); else n_pass++;
        n_checks++; if (o_z_d !== 32'h0) $display("FAIL reset_d: got %h expected 0", o_z_d); else n_pass++;
        n_checks++; if (o_z_n !== 3'd0) $display("FAIL reset_n: got %0d expected 0", o_z_n); else n_pass++;
        n_checks++; if (o_z_l !== 1'b0) $display("FAIL reset_l: got %b expected 0", o_z_l); else n_pass++;
        n_checks++; if (o_a_r !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_a_r); else n_pass++;
        n_checks++; if ({b_o_z_v, b_o_z_d, b_o_z_n} !== 10'h0) $display("FAIL reset_k1: got %h expected 0", {b_o_z_v, b_o_z_d, b_o_z_n}); else n_pass++;
        reset = 1'b0; i_z_r = 1'b1; b_i_z_r = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_words();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        n_checks++; if (o_z_v !== 1'b1) $display("FAIL full_v: got %b expected 1", o_z_v); else n_pass++;
        n_checks++; if (o_z_d !== 32'h44332211) $display("FAIL full_d: got %h expected 44332211", o_z_d); else n_pass++;
        n_checks++; if (o_z_n !== 3'd4) $display("FAIL full_n: got %0d expected 4", o_z_n); else n_pass++;
        n_checks++; if (o_z_l !== 1'b0) $display("FAIL full_l: got %b expected 0", o_z_l); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (o_z_v !== 1'b0) $display("FAIL full_drain: got %b expected 0", o_z_v); else n_pass++;
    endtask

    task automatic test_partial_flush();
        send(8'hAA, 0); send(8'hBB, 1);
        n_checks++; if (o_z_d !== 32'h0000BBAA) $display("FAIL flush_d: got %h expected 0000bbaa", o_z_d); else n_pass++;
        n_checks++; if (o_z_n !== 3'd2) $display("FAIL flush_n: got %0d expected 2", o_z_n); else n_pass++;
        n_checks++; if (o_z_l !== 1'b1) $display("FAIL flush_l: got %b expected 1", o_z_l); else n_pass++;
        send(8'hC1, 1);
        n_checks++; if (o_z_d !== 32'h000000C1) $display("FAIL flush_next_d: got %h expected 000000c1", o_z_d); else n_pass++;
        n_checks++; if (o_z_n !== 3'd1) $display("FAIL flush_next_n: got %0d expected 1", o_z_n); else n_pass++;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
        n_checks++; if ({o_z_n, o_z_l} !== {3'd4, 1'b1}) $display("FAIL last_on_final: got n=%0d l=%b expected n=4 l=1", o_z_n, o_z_l); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        int w0;
        send(8'h10, 0); send(8'h11, 0); send(8'h12, 0); send(8'h13, 0);
        w0 = dut_words;
        i_z_r = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 0);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    n_checks++; if (o_a_r !== 1'b0) $display("FAIL bp_ready: got %b expected 0", o_a_r); else n_pass++;
                    n_checks++; if (o_z_d !== 32'h13121110) $display("FAIL bp_hold: got %h expected 13121110", o_z_d); else n_pass++;
                end
                @(posedge clk); #1;
                i_z_r = 1'b1;
            end
        join
        n_checks++; if (o_z_d !== 32'h27262524) $display("FAIL bp_word3: got %h expected 27262524", o_z_d); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (dut_words - w0 !== 3) $display("FAIL bp_count: got %0d words expected 3", dut_words - w0); else n_pass++;
    endtask

    task automatic test_streaming();
        bit done = 0;
        int m0 = words_made;
        int w0 = dut_words;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(8'($urandom), (i == 63) || ($urandom_range(0, 4) == 0));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    if (!done) i_z_r = ($urandom_range(0, 2) != 0);
                end
            end
        join
        i_z_r = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (dut_words - w0 !== words_made - m0) $display("FAIL stream_count: got %0d words expected %0d", dut_words - w0, words_made - m0); else n_pass++;
        n_checks++; if (o_z_v !== 1'b0) $display("FAIL stream_idle: got %b expected 0", o_z_v); else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        int w0;
        send(8'h77, 0); send(8'h88, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if ({o_z_v, o_a_r} !== 2'b01) $display("FAIL rst_mid_state: got v=%b r=%b expected v=0 r=1", o_z_v, o_a_r); else n_pass++;
        w0 = dut_words;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        n_checks++; if (o_z_d !== 32'h04030201) $display("FAIL rst_mid_d: got %h expected 04030201", o_z_d); else n_pass++;
        n_checks++; if (o_z_n !== 3'd4) $display("FAIL rst_mid_n: got %0d expected 4", o_z_n); else n_pass++;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (dut_words - w0 !== 1) $display("FAIL rst_mid_count: got %0d words expected 1", dut_words - w0); else n_pass++;
    endtask

    task automatic test_single_beat();
        logic [7:0] d;
        logic       l;
        b_i_z_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            l = 1'($urandom);
            b_i_a_v = 1'b1; b_i_a_d = d; b_i_a_l = l;
            @(posedge clk); #1;
            n_checks++;
            if ({b_o_z_v, b_o_z_d, b_o_z_n, b_o_z_l, b_o_a_r} !== {1'b1, d, 1'b1, l, 1'b1})
                $display("FAIL k1_word: got v=%b d=%h n=%0d l=%b r=%b expected v=1 d=%h n=1 l=%b r=1",
                         b_o_z_v, b_o_z_d, b_o_z_n, b_o_z_l, b_o_a_r, d, l);
            else n_pass++;
        end
        b_i_a_v = 1'b0; b_i_a_d = 'x; b_i_a_l = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (b_o_z_v !== 1'b0) $display("FAIL k1_idle: got %b expected 0", b_o_z_v); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial_flush();
        test_back_pressure();
        test_streaming();
        test_reset_mid_word();
        test_single_beat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
